pkt_egress_reader: RTL and testbench

- Drains packet words from the fifo_sram read port (reb / fifo_output / fifo_empty) and retransmits them on the NetFPGA-style out_data/out_ctrl/out_wr/out_rdy interface.
- This is the reader end of the in_wr/in_rdy packet write path. A small skid buffer absorbs the 1-cycle fifo read latency so out_rdy backpressure never loses a word.
- Packet framing is tracked so that transmission can be gated at packet boundaries by tx_en, e.g. while the datapath processor is still working on the next packet.

---
 rtl/pkt_egress_reader.sv | 115 +++++++++++
 tb/tb_pkt_egress_reader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_egress_reader.sv
// Packet egress reader: drains fifo_sram words through a small skid buffer onto
// the out_data/out_ctrl/out_wr/out_rdy interface, starting packets only when tx_en allows.
//
// state | meaning
// IDLE  | between packets; a header word at the head may start a packet when tx_en=1
// HDR   | inside the header run (ctrl!=0 words)
// BODY  | inside the body; the next ctrl!=0 word is the EOP word
module pkt_egress_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int BUF_DEPTH  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    output logic                  reb,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic [CTRL_WIDTH-1:0] fifo_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  busy,
    output logic                  framing_err,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  word_cnt
);
    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;
    localparam logic [OCC_W:0] DEPTH = (OCC_W+1)'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    state_t            state;
    logic [WORD_W-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [OCC_W-1:0]  occ;
    logic              rd_pend;

    logic [WORD_W-1:0] head;
    logic              head_vld;
    logic              head_is_ctl;
    logic              allow;
    logic              drop;
    logic              pop;
    logic [OCC_W:0]    credit;

    assign head        = mem[rd_ptr];
    assign head_vld    = (occ != '0);
    assign head_is_ctl = |head[WORD_W-1:DATA_WIDTH];
    assign out_data    = head_vld ? head[DATA_WIDTH-1:0] : '0;
    assign out_ctrl    = head_vld ? head[WORD_W-1:DATA_WIDTH] : '0;

    // In-flight reads hold a slot, so a word returning next cycle always has room.
    assign credit = {1'b0, occ} + (OCC_W+1)'(rd_pend);
    assign reb    = !reset && !fifo_empty && (credit < DEPTH);

    assign allow  = (state == IDLE) ? (tx_en && head_is_ctl) : 1'b1;
    assign out_wr = head_vld && out_rdy && allow;
    assign drop   = (state == IDLE) && head_vld && !head_is_ctl;
    assign pop    = out_wr || drop;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rd_pend && !reset)
            mem[wr_ptr] <= {fifo_ctrl, fifo_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occ         <= '0;
            rd_pend     <= 1'b0;
            framing_err <= 1'b0;
            pkt_cnt     <= '0;
            word_cnt    <= '0;
        end else begin
            rd_pend <= reb;
            if (rd_pend)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            occ <= occ + OCC_W'(rd_pend) - OCC_W'(pop);
            if (out_wr)
                word_cnt <= word_cnt + CNT_WIDTH'(1);

            case (state)
                IDLE: begin
                    // A body word with no header in front of it is discarded.
                    if (drop)
                        framing_err <= 1'b1;
                    else if (out_wr)
                        state <= HDR;
                end
                HDR: begin
                    if (out_wr && !head_is_ctl)
                        state <= BODY;
                end
                BODY: begin
                    if (out_wr && head_is_ctl) begin
                        pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_egress_reader.sv
// Directed bench for pkt_egress_reader: a queue-based fifo model feeds the DUT and
// a scoreboard of expected egress words is checked on every out_wr.
module tb_pkt_egress_reader;
    localparam int DW = 64;
    localparam int CW = 8;

    typedef logic [CW+DW-1:0] word_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tx_en = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          reb;
    logic [DW-1:0] fifo_data = '0;
    logic [CW-1:0] fifo_ctrl = '0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr;
    logic          out_rdy = 1'b0;
    logic          busy;
    logic          framing_err;
    logic [31:0]   pkt_cnt;
    logic [31:0]   word_cnt;

    pkt_egress_reader dut (
        .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(fifo_empty), .reb(reb),
        .fifo_data(fifo_data), .fifo_ctrl(fifo_ctrl), .out_data(out_data), .out_ctrl(out_ctrl),
        .out_wr(out_wr), .out_rdy(out_rdy), .busy(busy), .framing_err(framing_err),
        .pkt_cnt(pkt_cnt), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    word_t src_q[$];
    word_t exp_q[$];
    word_t pend;
    bit    pend_v = 1'b0;
    int    checks = 0;
    int    failures = 0;
    int    wr_seen = 0;
    int    inflight = 0;
    logic  last_reb = 1'b0;
    logic  last_out_wr = 1'b0;
    bit    bp_on = 1'b0;
    bit    crd_on = 1'b0;
    int    bp_idx = 0;
    bit    bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int t, input int i);
        return {t, i};
    endfunction

    task automatic push(input logic [7:0] c, input logic [63:0] d, input bit tx);
        src_q.push_back({c, d});
        if (tx) exp_q.push_back({c, d});
        fifo_empty = 1'b0;
    endtask

    task automatic load_pkt(input int t, input int nbody);
        push(8'hFF, mk(t, 0), 1'b1);
        for (int i = 1; i <= nbody; i++) push(8'h00, mk(t, i), 1'b1);
        push(8'h80, mk(t, nbody + 1), 1'b1);
    endtask

    // One clock: sample at the falling edge, then update the fifo model after the rising edge.
    task automatic cycle();
        word_t e;
        @(negedge clk);
        last_reb    = reb;
        last_out_wr = out_wr;
        if (reset) begin
            inflight = 0;
        end else begin
            if (crd_on && inflight == 4) chk("credit_reb", 128'(reb), 128'(0));
            if (out_wr) begin
                chk("exp_avail", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("egress_word", 128'({out_ctrl, out_data}), 128'(e));
                end
                wr_seen++;
            end
            inflight = inflight + int'(reb) - int'(out_wr);
        end
        pend_v = 1'b0;
        if (reb && src_q.size() != 0) begin
            pend   = src_q.pop_front();
            pend_v = 1'b1;
        end
        @(posedge clk);
        #1;
        if (pend_v) {fifo_ctrl, fifo_data} = pend;
        fifo_empty = (src_q.size() == 0);
        if (bp_on) begin
            out_rdy = bp_pat[bp_idx % 4];
            bp_idx++;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_done", 128'(exp_q.size() == 0 && src_q.size() == 0), 128'(1));
        repeat (3) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        exp_q.delete();
        inflight = 0;
        bp_on = 1'b0;
        crd_on = 1'b0;
    endtask

    initial begin
        int base;
        int n;

        // Reset state
        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_ferr", 128'(framing_err), 128'(0));
        chk("rst_pkt_cnt", 128'(pkt_cnt), 128'(0));
        chk("rst_word_cnt", 128'(word_cnt), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        cycle();
        chk("rst_reb", 128'(last_reb), 128'(0));
        chk("rst_out_wr", 128'(last_out_wr), 128'(0));

        // Single packet: latency and back-to-back streaming
        tx_en = 1'b1;
        out_rdy = 1'b1;
        load_pkt(1, 4);
        src_q.push_front(src_q.pop_front());
        exp_q.delete();
        src_q.delete();
        push(8'hFF, mk(1, 0), 1'b1);
        push(8'hFF, mk(1, 1), 1'b1);
        for (int i = 2; i < 6; i++) push(8'h00, mk(1, i), 1'b1);
        push(8'h80, mk(1, 6), 1'b1);
        cycle();
        chk("lat_c0_reb", 128'(last_reb), 128'(1));
        chk("lat_c0_wr", 128'(last_out_wr), 128'(0));
        cycle();
        chk("lat_c1_wr", 128'(last_out_wr), 128'(0));
        for (int i = 0; i < 7; i++) begin
            cycle();
            chk("single_stream_wr", 128'(last_out_wr), 128'(1));
            if (i == 0) chk("single_busy_mid", 128'(busy), 128'(1));
        end
        cycle();
        chk("single_stream_end", 128'(last_out_wr), 128'(0));
        drain(50);
        chk("single_pkt_cnt", 128'(pkt_cnt), 128'(1));
        chk("single_word_cnt", 128'(word_cnt), 128'(7));
        chk("single_busy_end", 128'(busy), 128'(0));

        // Backpressure: out_rdy 1-0-0-1
        do_reset();
        tx_en = 1'b1;
        out_rdy = bp_pat[0];
        bp_idx = 1;
        bp_on = 1'b1;
        crd_on = 1'b1;
        base = wr_seen;
        load_pkt(2, 18);
        drain(200);
        bp_on = 1'b0;
        crd_on = 1'b0;
        out_rdy = 1'b1;
        chk("bp_words_seen", 128'(wr_seen - base), 128'(20));
        chk("bp_word_cnt", 128'(word_cnt), 128'(20));
        chk("bp_pkt_cnt", 128'(pkt_cnt), 128'(1));

        // Gating: tx_en dropped during packet A, packet B held until re-enabled
        do_reset();
        tx_en = 1'b1;
        out_rdy = 1'b1;
        base = wr_seen;
        load_pkt(3, 6);
        n = 0;
        while (wr_seen - base < 3 && n < 50) begin
            cycle();
            n++;
        end
        chk("gate_third_word", 128'(wr_seen - base), 128'(3));
        tx_en = 1'b0;
        load_pkt(4, 3);
        repeat (20) cycle();
        chk("gate_a_words", 128'(wr_seen - base), 128'(8));
        chk("gate_a_pkt_cnt", 128'(pkt_cnt), 128'(1));
        chk("gate_busy_held", 128'(busy), 128'(0));
        chk("gate_b_pending", 128'(exp_q.size()), 128'(5));
        tx_en = 1'b1;
        cycle();
        chk("gate_b_start", 128'(last_out_wr), 128'(1));
        drain(50);
        chk("gate_pkt_cnt", 128'(pkt_cnt), 128'(2));
        chk("gate_word_cnt", 128'(word_cnt), 128'(13));

        // Framing error: stray body word dropped even with tx_en=0 and out_rdy=0
        do_reset();
        tx_en = 1'b0;
        out_rdy = 1'b0;
        push(8'h00, mk(5, 0), 1'b0);
        repeat (5) cycle();
        chk("ferr_set", 128'(framing_err), 128'(1));
        chk("ferr_no_word", 128'(word_cnt), 128'(0));
        tx_en = 1'b1;
        out_rdy = 1'b1;
        push(8'h00, mk(5, 1), 1'b0);
        load_pkt(6, 2);
        drain(50);
        chk("ferr_sticky", 128'(framing_err), 128'(1));
        chk("ferr_pkt_cnt", 128'(pkt_cnt), 128'(1));
        chk("ferr_word_cnt", 128'(word_cnt), 128'(4));

        // Reset mid-packet with three words buffered
        do_reset();
        tx_en = 1'b1;
        out_rdy = 1'b1;
        base = wr_seen;
        push(8'hFF, mk(7, 0), 1'b1);
        for (int i = 1; i < 6; i++) push(8'h00, mk(7, i), 1'b1);
        n = 0;
        while (wr_seen - base < 3 && n < 50) begin
            cycle();
            n++;
        end
        out_rdy = 1'b0;
        repeat (4) cycle();
        chk("mid_src_fetched", 128'(src_q.size()), 128'(0));
        chk("mid_busy_body", 128'(busy), 128'(1));
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        exp_q.delete();
        inflight = 0;
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_pkt_cnt", 128'(pkt_cnt), 128'(0));
        chk("mid_rst_word_cnt", 128'(word_cnt), 128'(0));
        chk("mid_rst_out_data", 128'(out_data), 128'(0));
        out_rdy = 1'b1;
        cycle();
        chk("mid_rst_reb", 128'(last_reb), 128'(0));
        chk("mid_rst_out_wr", 128'(last_out_wr), 128'(0));
        load_pkt(8, 2);
        drain(50);
        chk("mid_new_pkt_cnt", 128'(pkt_cnt), 128'(1));
        chk("mid_new_word_cnt", 128'(word_cnt), 128'(4));
        chk("mid_new_ferr", 128'(framing_err), 128'(0));

        // Back-to-back: 4 packets of 5 words
        do_reset();
        tx_en = 1'b1;
        out_rdy = 1'b1;
        for (int p = 0; p < 4; p++) load_pkt(10 + p, 3);
        cycle();
        n = 0;
        while (!last_out_wr && n < 10) begin
            cycle();
            n++;
        end
        chk("b2b_first_wr", 128'(last_out_wr), 128'(1));
        for (int i = 1; i < 20; i++) begin
            cycle();
            chk("b2b_consec_wr", 128'(last_out_wr), 128'(1));
        end
        cycle();
        chk("b2b_end_wr", 128'(last_out_wr), 128'(0));
        drain(20);
        chk("b2b_pkt_cnt", 128'(pkt_cnt), 128'(4));
        chk("b2b_word_cnt", 128'(word_cnt), 128'(20));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
